// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux. One requester owns the mux at a
// time; a grant is bounded by HOLD_MAX cycles while others wait, and every
// grant is followed by one dead (GAP) cycle so the mux never switches owners
// under a live grant.
module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic        gnt_done
);

  localparam int         NUM_REQ = 16;
  localparam logic [7:0] HOLD    = 8'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt, sel_nxt, winner;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic        any_req, others, rel;

  // Rotate req so ptr sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[15:0];
    winner  = ptr;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req_rot[k]) winner = ptr + 4'(k);
  end

  assign any_req = |req;
  assign others  = |(req & ~(16'h1 << sel));
  // Hold limit only bites when someone else is actually waiting.
  assign rel     = !req[sel] || !en || ((hcnt >= HOLD) && others);

  // Next-state, pointer, select and hold-counter decisions.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    hcnt_nxt  = hcnt;
    case (state)
      IDLE, GAP: begin
        if (en && any_req) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          hcnt_nxt  = 8'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (rel) begin
          state_nxt = GAP;
          ptr_nxt   = sel + 4'd1;
        end else if (hcnt < HOLD) begin
          hcnt_nxt  = hcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset clears outputs immediately since they decode state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 4'd0;
      sel   <= 4'd0;
      hcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // One-hot grant decode, one bit per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gnt
    assign gnt[i] = (state == GRANT) && (sel == 4'(i));
  end

  assign gnt_valid = (state == GRANT);
  assign gnt_done  = (state == GAP);

endmodule
